// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron weight sequencer.
package neuron_pkg;

    localparam int WEIGHT_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAIN,
        BIAS,
        ACT,
        HOLD
    } seq_state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/act_delay_line.sv
// Fixed-depth shift register that carries {valid, data} so each activation
// reaches the MAC in the same cycle as its weight from memory.
module act_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [DEPTH-1:0] vld
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

    // Valid bit of every stage, MSB of each entry.
    always_comb begin
        vld = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            vld[i] = stage[i][WIDTH-1];
        end
    end

endmodule

// File: rtl/neuron_weight_sequencer.sv
// Per-neuron weight-address sequencer and MAC strobe controller.
// Define NEURON_SEQ_PERF_EN to add the stall_cycles performance counter.
module neuron_weight_sequencer
    import neuron_pkg::*;
#(
    parameter int NUM_WEIGHTS = 784,
    parameter int DATA_WIDTH  = 16,
    parameter int READ_LAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WEIGHT_ADDR_W-1:0] weight_addr,
    output logic [DATA_WIDTH-1:0]    mac_act,
    output logic                     mac_clr,
    output logic                     mac_en,
    output logic                     bias_en,
    output logic                     act_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
`ifdef NEURON_SEQ_PERF_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int CNT_W = (NUM_WEIGHTS > 1) ? clog2(NUM_WEIGHTS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WEIGHTS - 1);
    // Every delay-line stage except the output one.
    localparam logic [READ_LAT-1:0] UPSTREAM_MASK = {READ_LAT{1'b1}} >> 1;

    seq_state_t          state;
    logic [CNT_W-1:0]    count;
    logic                hs;
    logic                drain_done;
    logic [DATA_WIDTH:0] dl_q;
    logic [READ_LAT-1:0] dl_vld;

    // in_ready is only ever high in FETCH, so it qualifies the handshake.
    assign hs          = in_ready & in_valid;
    assign weight_addr = WEIGHT_ADDR_W'(count);

    act_delay_line #(
        .DEPTH (READ_LAT),
        .WIDTH (DATA_WIDTH + 1)
    ) u_act_delay_line (
        .clk (clk),
        .rst (rst),
        .d   ({hs, in_data}),
        .q   (dl_q),
        .vld (dl_vld)
    );

    assign mac_en  = dl_q[DATA_WIDTH];
    assign mac_act = dl_q[DATA_WIDTH-1:0];

    // Last activation sits in the output stage, so its mac_en fires this cycle.
    assign drain_done = (dl_vld & UPSTREAM_MASK) == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b0;
            mac_clr   <= 1'b0;
            bias_en   <= 1'b0;
            act_en    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mac_clr <= 1'b0;
            bias_en <= 1'b0;
            act_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        count   <= '0;
                        mac_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    state    <= FETCH;
                    count    <= '0;
                    in_ready <= 1'b1;
                end
                FETCH: begin
                    if (hs) begin
                        if (count == LAST_IDX) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state   <= BIAS;
                        bias_en <= 1'b1;
                    end
                end
                BIAS: begin
                    state  <= ACT;
                    act_en <= 1'b1;
                end
                ACT: begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef NEURON_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == CLEAR) begin
            stall_cycles <= '0;
        end else if (state == FETCH && !in_valid && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_neuron_weight_sequencer.sv
// Self-checking bench for neuron_weight_sequencer: instance 0 has 4 weights and
// read latency 1, instance 1 has 1 weight and read latency 3.
module tb_neuron_weight_sequencer;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_s     [2];
    logic          in_valid_s  [2];
    logic          out_ready_s [2];
    logic [DW-1:0] in_data_s   [2];
    logic          in_ready_s  [2];
    logic          mac_clr_s   [2];
    logic          mac_en_s    [2];
    logic          bias_en_s   [2];
    logic          act_en_s    [2];
    logic          out_valid_s [2];
    logic          busy_s      [2];
    logic [31:0]   weight_addr_s [2];
    logic [DW-1:0] mac_act_s   [2];
`ifdef NEURON_SEQ_PERF_EN
    logic [31:0]   stall_s     [2];
`endif

    neuron_weight_sequencer #(
        .NUM_WEIGHTS (4),
        .DATA_WIDTH  (DW),
        .READ_LAT    (1)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (start_s[0]),
        .in_data     (in_data_s[0]),
        .in_valid    (in_valid_s[0]),
        .in_ready    (in_ready_s[0]),
        .weight_addr (weight_addr_s[0]),
        .mac_act     (mac_act_s[0]),
        .mac_clr     (mac_clr_s[0]),
        .mac_en      (mac_en_s[0]),
        .bias_en     (bias_en_s[0]),
        .act_en      (act_en_s[0]),
        .out_valid   (out_valid_s[0]),
        .out_ready   (out_ready_s[0]),
        .busy        (busy_s[0])
`ifdef NEURON_SEQ_PERF_EN
        ,
        .stall_cycles (stall_s[0])
`endif
    );

    neuron_weight_sequencer #(
        .NUM_WEIGHTS (1),
        .DATA_WIDTH  (DW),
        .READ_LAT    (3)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start_s[1]),
        .in_data     (in_data_s[1]),
        .in_valid    (in_valid_s[1]),
        .in_ready    (in_ready_s[1]),
        .weight_addr (weight_addr_s[1]),
        .mac_act     (mac_act_s[1]),
        .mac_clr     (mac_clr_s[1]),
        .mac_en      (mac_en_s[1]),
        .bias_en     (bias_en_s[1]),
        .act_en      (act_en_s[1]),
        .out_valid   (out_valid_s[1]),
        .out_ready   (out_ready_s[1]),
        .busy        (busy_s[1])
`ifdef NEURON_SEQ_PERF_EN
        ,
        .stall_cycles (stall_s[1])
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // {in_ready, mac_clr, mac_en, bias_en, act_en, out_valid, busy}
    function automatic logic [6:0] strobes(input int d);
        return {in_ready_s[d], mac_clr_s[d], mac_en_s[d], bias_en_s[d],
                act_en_s[d], out_valid_s[d], busy_s[d]};
    endfunction

    function automatic int nw_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int rl_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Evaluation description: idle cycles before each item, item values,
    // cycles out_ready stays low in HOLD, and whether start is pulsed in HOLD.
    int          gap_q [8];
    logic [DW-1:0] val_q [8];
    int          hold_wait;
    bit          start_in_hold;

    // Cycle t=0 carries start. Reference timeline from the behaviour rules:
    // CLEAR at 1, FETCH from 2, item k handshakes at h[k], mac_en at h[k]+RL,
    // bias one cycle after the last mac_en, then act, then HOLD.
    task automatic run_eval(input int d);
        int nw, rl, acc, hl, bcyc, acyc, hh, endc, done_n, mac_k, stall_sum;
        int h [8];
        bit exp_mac;
        logic [6:0] exp_s;
        nw = nw_of(d);
        rl = rl_of(d);
        acc = 2;
        stall_sum = 0;
        for (int k = 0; k < nw; k++) begin
            acc += gap_q[k];
            stall_sum += gap_q[k];
            h[k] = acc;
            acc++;
        end
        hl   = h[nw-1];
        bcyc = hl + rl + 1;
        acyc = bcyc + 1;
        hh   = acyc + 1;
        endc = hh + hold_wait;
        for (int t = 0; t <= endc + 1; t++) begin
            @(posedge clk);
            #1;
            done_n = 0;
            for (int k = 0; k < nw; k++) if (h[k] < t) done_n++;
            if (t == 0) start_s[d] = 1'b1;
            else if (t > endc) start_s[d] = 1'b0;
            else if (start_in_hold && t >= hh) start_s[d] = 1'b1;
            else start_s[d] = ($urandom_range(3) == 0);
            if (t >= 2 && t <= hl) begin
                in_valid_s[d] = (t == h[done_n]);
                in_data_s[d]  = in_valid_s[d] ? val_q[done_n] : DW'($urandom);
            end else begin
                in_valid_s[d] = 1'($urandom_range(1));
                in_data_s[d]  = DW'($urandom);
            end
            if (t == endc) out_ready_s[d] = 1'b1;
            else if (t >= hh) out_ready_s[d] = 1'b0;
            else out_ready_s[d] = 1'($urandom_range(1));
            @(negedge clk);
            exp_mac = 1'b0;
            mac_k = 0;
            for (int k = 0; k < nw; k++) begin
                if (h[k] + rl == t) begin
                    exp_mac = 1'b1;
                    mac_k = k;
                end
            end
            exp_s = {(t >= 2 && t <= hl), (t == 1), exp_mac, (t == bcyc),
                     (t == acyc), (t >= hh && t <= endc), (t >= 1 && t <= endc)};
            check_eq("strobes", 64'(strobes(d)), 64'(exp_s));
            if (t >= 2 && t <= hl) check_eq("weight_addr", 64'(weight_addr_s[d]), 64'(done_n));
            if (exp_mac) check_eq("mac_act", 64'(mac_act_s[d]), 64'(val_q[mac_k]));
        end
`ifdef NEURON_SEQ_PERF_EN
        check_eq("stall_cycles", 64'(stall_s[d]), 64'(stall_sum));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq({tag, "_strobes"}, 64'(strobes(d)), 64'd0);
            check_eq({tag, "_addr"}, 64'(weight_addr_s[d]), 64'd0);
            check_eq({tag, "_mac_act"}, 64'(mac_act_s[d]), 64'd0);
`ifdef NEURON_SEQ_PERF_EN
            check_eq({tag, "_stall"}, 64'(stall_s[d]), 64'd0);
`endif
        end
    endtask

    task automatic clear_desc();
        for (int k = 0; k < 8; k++) begin
            gap_q[k] = 0;
            val_q[k] = DW'(k + 1);
        end
        hold_wait = 0;
        start_in_hold = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            in_valid_s[d] = 1'b0;
            out_ready_s[d] = 1'b0;
            in_data_s[d] = '0;
        end
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Data 1..4, no stalls, immediate acceptance.
        clear_desc();
        run_eval(0);

        // Three-cycle in_valid gap after the second handshake.
        clear_desc();
        gap_q[2] = 3;
        run_eval(0);

        // out_ready held low five cycles in HOLD with start pulsed there.
        clear_desc();
        hold_wait = 5;
        start_in_hold = 1'b1;
        run_eval(0);

        // Reset in FETCH after two handshakes.
        @(posedge clk);
        #1;
        start_s[0] = 1'b1;
        in_valid_s[0] = 1'b1;
        out_ready_s[0] = 1'b1;
        in_data_s[0] = 16'h0011;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("mid_fetch_addr", 64'(weight_addr_s[0]), 64'd2);
        check_eq("mid_fetch_busy", 64'(busy_s[0]), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("post_rst_quiet", 64'(strobes(0)), 64'd0);
        end
        in_valid_s[0] = 1'b0;
        out_ready_s[0] = 1'b0;
        clear_desc();
        run_eval(0);

        // Single weight, read latency 3.
        clear_desc();
        val_q[0] = 16'hBEEF;
        hold_wait = 1;
        run_eval(1);
        clear_desc();
        gap_q[0] = 2;
        val_q[0] = 16'h1234;
        run_eval(1);

        // Randomized evaluations on both instances.
        for (int n = 0; n < 30; n++) begin
            int d;
            d = int'($urandom_range(1));
            clear_desc();
            for (int k = 0; k < nw_of(d); k++) begin
                gap_q[k] = ($urandom_range(2) == 0) ? int'($urandom_range(3)) : 0;
                val_q[k] = DW'($urandom);
            end
            hold_wait = int'($urandom_range(4));
            start_in_hold = 1'($urandom_range(1));
            run_eval(d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/neuron_weight_sequencer.md
Name: neuron_weight_sequencer

Overview:
- Controls one neuron's weight memory, which has a registered read with 1-cycle latency and a 32-bit local address.
- Accepts a stream of input activations and issues the matching weight address for each one.
- Delays each activation so it reaches the MAC in the same cycle as its weight, then sequences MAC clear, accumulate, bias and activation strobes.
- Holds the finished result on a valid/ready output handshake; one instance per neuron, sitting between the layer input buffer and the neuron MAC.

Parameters:
- NUM_WEIGHTS, 784: activations (and weights) per neuron.
- DATA_WIDTH, 16: activation width in bits.
- READ_LAT, 1: weight memory read latency in cycles. Legal range 1..3.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse that begins one neuron evaluation.
- in_data  in  DATA_WIDTH  activation value.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts in_data.
- weight_addr  out  32  local address to the weight memory.
- mac_act  out  DATA_WIDTH  activation delayed by READ_LAT.
- mac_clr  out  1  clear accumulator (1-cycle pulse).
- mac_en  out  1  accumulate mac_act × weight_out this cycle.
- bias_en  out  1  add bias this cycle.
- act_en  out  1  apply activation function this cycle.
- out_valid  out  1  neuron result ready.
- out_ready  in  1  downstream takes the result.
- busy  out  1  not in IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, delay pipeline cleared. All outputs 0: weight_addr, mac_act, mac_clr, mac_en, bias_en, act_en, out_valid, busy, in_ready.
- Reset mid-operation aborts the evaluation. No strobe may fire after reset asserts.
- States: IDLE, CLEAR, FETCH, DRAIN, BIAS, ACT, HOLD.
- IDLE:
  - start=1 -> CLEAR.
  - start is ignored in every other state.
- CLEAR:
  - mac_clr=1 for exactly one cycle; count=0.
  - -> FETCH.
- FETCH:
  - in_ready=1; weight_addr=count, combinational from the count register.
  - Handshake (in_valid & in_ready): count increments and in_data enters a READ_LAT-deep delay line with a valid bit.
  - In_valid low is a stall: weight_addr holds and no valid enters the pipe.
  - Handshake with count==NUM_WEIGHTS-1 -> DRAIN; in_ready drops the following cycle.
- Pipeline output: mac_en = valid bit at the end of the delay line; mac_act = the delayed data.
  - mac_en therefore fires exactly READ_LAT cycles after each handshake.
  - mac_en pulses exactly NUM_WEIGHTS times per evaluation.
- DRAIN:
  - Waits until the delay line is empty, i.e. the last mac_en has fired.
  - -> BIAS.
- BIAS: bias_en=1 for one cycle; -> ACT.
- ACT: act_en=1 for one cycle; -> HOLD.
- HOLD:
  - out_valid=1 and stays high until out_ready is sampled high -> IDLE.
  - out_ready asserted in the cycle of entry completes the transfer that same cycle.
- out_ready outside HOLD is ignored.
- busy=1 in every state except IDLE.
- weight_addr range is 0..NUM_WEIGHTS-1 and never wraps. count is wide enough for NUM_WEIGHTS-1; it is zero-extended to 32 bits.
- Boundary NUM_WEIGHTS=1: the single handshake goes directly to DRAIN.
- Minimum evaluation time with no stalls: 1 (CLEAR) + NUM_WEIGHTS + READ_LAT + 2 cycles to out_valid.

Optional Feature:
- Macro: NEURON_SEQ_PERF_EN.
- Defined:
  - Adds output port stall_cycles (32 bits).
  - Counts FETCH cycles with in_valid=0; saturates at 2^32-1.
  - Cleared in CLEAR and by reset; holds its value through HOLD and IDLE.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package neuron_pkg holds:
  - the state enum seq_state_t with the 7 states;
  - WEIGHT_ADDR_W=32;
  - the function clog2 used for count width.
- Sub-module act_delay_line, parameterised DEPTH=READ_LAT and WIDTH=DATA_WIDTH+1: a shift register carrying the valid bit and the data. Async reset clears the valid bits.
- The FSM and address counter live in the top module.

Test Plan:
- NUM_WEIGHTS=4, READ_LAT=1, in_valid held high, in_data=1,2,3,4:
  - weight_addr steps 0,1,2,3;
  - mac_en high 4 consecutive cycles, mac_act=1,2,3,4, each one cycle after its handshake;
  - then bias_en, then act_en;
  - out_valid 9 cycles after start.
- Same setup with in_valid low for 3 cycles after the 2nd handshake:
  - weight_addr holds at 2 during the gap;
  - a 3-cycle gap in mac_en;
  - stall_cycles=3 with NEURON_SEQ_PERF_EN.
- Hold out_ready low for 5 cycles in HOLD, then raise it:
  - out_valid stays 1 for 6 cycles;
  - a start pulse applied during HOLD is ignored;
  - IDLE is entered after the out_ready cycle.
- Assert rst while in FETCH with count=2:
  - all outputs drop to 0 immediately (asynchronously);
  - no mac_en, bias_en or act_en fires after reset;
  - a new start produces weight_addr beginning at 0.
- NUM_WEIGHTS=1, READ_LAT=3:
  - single handshake;
  - mac_en fires 3 cycles later;
  - bias_en the cycle after it;
  - exactly one mac_en per evaluation.
